pattern_tx: RTL and testbench
=============================

PATTERN_TX -- requirements
Module: pattern_tx

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, number of payload bits per frame (legal range 1..32).
REQ-002 SHALL provide parameter IDLE_LEVEL, default 1'b0, level driven on w when no frame is active.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port clr  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port data_in  input  WIDTH  parallel word to serialize, sampled only on acceptance.
REQ-006 SHALL have port load  input  1  request to start a frame.
REQ-007 SHALL have port ready  output  1  high when a load will be accepted.
REQ-008 SHALL have port w  output  1  serial bit stream, one bit per clock, MSB first, registered.
REQ-009 SHALL have port w_valid  output  1  high on every cycle in which w carries a frame bit.
REQ-010 SHALL have port done  output  1  one-cycle pulse after the last frame bit.

Function
REQ-011 SHALL implement a Moore FSM with states IDLE, SHIFT, PARITY, DONE; all outputs SHALL be decoded from registered state only.
REQ-012 Acceptance SHALL occur on a rising edge with load=1 and ready=1; ready SHALL be 1 only in IDLE.
REQ-013 On acceptance: capture data_in into a shift register, clear the bit counter, go to SHIFT.
REQ-014 SHIFT: w = current MSB of the shift register, w_valid=1; shift left by one and increment the counter each cycle; the first bit SHALL appear in the cycle immediately after acceptance.
REQ-015 After WIDTH SHIFT cycles: go to PARITY if PATTERN_TX_PARITY_EN is defined, else to DONE.
REQ-016 DONE SHALL last exactly one cycle with done=1, w=IDLE_LEVEL, w_valid=0, ready=0, then go to IDLE.
REQ-017 In IDLE: w=IDLE_LEVEL, w_valid=0, done=0, ready=1.
REQ-018 load=1 while ready=0 SHALL be ignored entirely (not queued); data_in changes after acceptance SHALL NOT affect the frame.
REQ-019 Minimum spacing between acceptances SHALL be WIDTH+2 cycles (WIDTH+3 with parity); load held high continuously SHALL produce back-to-back frames at that spacing.
REQ-020 WIDTH=1 SHALL yield exactly one SHIFT cycle.
REQ-021 The bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL NOT wrap within a frame.

Reset
REQ-022 clr=1 at a rising edge SHALL force IDLE, clear the shift register, counter and parity accumulator; after the edge ready=1, w=IDLE_LEVEL, w_valid=0, done=0.
REQ-023 clr SHALL take priority over load on the same edge; a frame aborted by clr SHALL NOT produce a done pulse.

Configuration
REQ-024 Macro PATTERN_TX_PARITY_EN defined: PARITY state present, lasting one cycle with w = XOR of all WIDTH payload bits (even parity over payload+parity), w_valid=1.
REQ-025 Macro undefined: PARITY state, parity accumulator and associated logic SHALL be absent; SHIFT goes directly to DONE.

Structure
REQ-026 A shared package pattern_pkg SHALL hold the state encoding constants (IDLE=2'd0, SHIFT=2'd1, PARITY=2'd2, DONE=2'd3), reused by the matching sequence detector bench.
REQ-027 One sub-module pattern_shreg (WIDTH-bit loadable left-shift register exposing its MSB) SHALL be instantiated; the FSM and counter remain in pattern_tx.

Verification
REQ-028 Reset: clr=1 for 2 cycles with load=1 -> ready=1, w=0, w_valid=0, done=0 after release; no frame starts during clr.
REQ-029 WIDTH=8, no parity, data_in=8'b0011_0101 accepted at cycle 0 -> w=0,0,1,1,0,1,0,1 with w_valid=1 on cycles 1-8, done=1 on cycle 9 only, ready=1 on cycle 10.
REQ-030 Parity enabled, data_in=8'b0000_0111 -> bits 0,0,0,0,0,1,1,1 on cycles 1-8, parity bit w=1 on cycle 9, done on cycle 10.
REQ-031 Busy ignore: accept 8'hA5, pulse load with data_in=8'hFF at cycle 3 -> stream remains 1,0,1,0,0,1,0,1; no second frame follows.
REQ-032 Abort: accept 8'hF0, clr=1 at cycle 4 -> from cycle 5 w=0, w_valid=0, ready=1; done never asserts.
REQ-033 Back-to-back: load held high with 8'h81 then 8'h7E -> second frame's first bit (0) on cycle 11, no gap other than the DONE and IDLE cycles.

Source files
------------

// File: rtl/pattern_pkg.sv
// Shared definitions for the pattern transmitter and its companion sequence
// detector bench.
//
// Contents:
//   IDLE/SHIFT/PARITY/DONE - fixed 2-bit state encodings
//   state_e                - typed state enum built on those encodings
package pattern_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  typedef enum logic [1:0] {
    StIdle   = IDLE,
    StShift  = SHIFT,
    StParity = PARITY,
    StDone   = DONE
  } state_e;

endpackage

// File: rtl/pattern_shreg.sv
// WIDTH-bit loadable left-shift register exposing its MSB.
//
// Ports:
//   clk     - clock, rising edge
//   clr     - synchronous active-high clear
//   load    - capture data_in (has priority over shift)
//   shift   - shift left by one, zero fill
//   data_in - parallel word
//   msb     - current most significant bit
module pattern_shreg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data_in,
  output logic             msb
);

  logic [WIDTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = data_in;
    end else if (shift) begin
      sr_d = sr_q << 1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign msb = sr_q[WIDTH-1];

endmodule

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: accepts a parallel word and sends it MSB first,
// one bit per clock, followed (optionally) by an even-parity bit and a
// one-cycle done pulse. All outputs are decoded from registered state.
//
// Build option: define PATTERN_TX_PARITY_EN to append the parity bit.
//
// Ports:
//   clk     - clock, rising edge
//   clr     - synchronous active-high reset, overrides load
//   data_in - word to send, sampled only on acceptance
//   load    - start request, accepted when ready=1
//   ready   - high in idle only
//   w       - serial bit stream (IDLE_LEVEL when no frame bit)
//   w_valid - w carries a frame bit
//   done    - one-cycle pulse after the last frame bit
module pattern_tx
  import pattern_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             w,
  output logic             w_valid,
  output logic             done
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            accept;
  logic            shift_en;
  logic            msb;

`ifdef PATTERN_TX_PARITY_EN
  logic par_q, par_d;
`endif

  pattern_shreg #(
    .WIDTH(WIDTH)
  ) u_shreg (
    .clk    (clk),
    .clr    (clr),
    .load   (accept),
    .shift  (shift_en),
    .data_in(data_in),
    .msb    (msb)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    shift_en = 1'b0;
    ready    = 1'b0;
    w        = IDLE_LEVEL;
    w_valid  = 1'b0;
    done     = 1'b0;
    case (state_q)
      StIdle: begin
        ready = 1'b1;
        if (load) begin
          accept  = 1'b1;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        w        = msb;
        w_valid  = 1'b1;
        shift_en = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
`ifdef PATTERN_TX_PARITY_EN
          state_d = StParity;
`else
          state_d = StDone;
`endif
        end
      end
`ifdef PATTERN_TX_PARITY_EN
      StParity: begin
        w       = par_q;
        w_valid = 1'b1;
        state_d = StDone;
      end
`endif
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef PATTERN_TX_PARITY_EN
  // Fold in each bit as it leaves the shift register.
  always_comb begin
    par_d = par_q;
    if (accept) begin
      par_d = 1'b0;
    end else if (shift_en) begin
      par_d = par_q ^ msb;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pattern_tx.sv
// Self-checking bench for pattern_tx. A frame-level reference model tracks
// the age of the frame in flight and derives expected outputs arithmetically.
module tb_pattern_tx;

  localparam int W = 8;
  localparam logic IDLE_LVL = 1'b0;
`ifdef PATTERN_TX_PARITY_EN
  localparam int PE = 1;
`else
  localparam int PE = 0;
`endif
  localparam int L = W + 2 + PE;  // cycles from acceptance back to idle

  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         load = 1'b0;
  logic         ready, w, w_valid, done;

  logic         load1 = 1'b0;
  logic [0:0]   data1 = '0;
  logic         ready1, w1, w_valid1, done1;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  // Reference model: frame age 1..W are payload bits, W+1 parity if enabled,
  // L-1 is the done cycle, age L returns to idle.
  bit           m_active = 1'b0;
  int           m_age = 0;
  logic [W-1:0] m_data = '0;

  pattern_tx #(
    .WIDTH     (W),
    .IDLE_LEVEL(IDLE_LVL)
  ) dut (
    .clk    (clk),
    .clr    (clr),
    .data_in(data_in),
    .load   (load),
    .ready  (ready),
    .w      (w),
    .w_valid(w_valid),
    .done   (done)
  );

  pattern_tx #(
    .WIDTH     (1),
    .IDLE_LEVEL(IDLE_LVL)
  ) dut1 (
    .clk    (clk),
    .clr    (clr),
    .data_in(data1),
    .load   (load1),
    .ready  (ready1),
    .w      (w1),
    .w_valid(w_valid1),
    .done   (done1)
  );

  always #5 clk = ~clk;

  // {w, w_valid, done, ready}
  function automatic logic [3:0] model_out();
    if (!m_active) return {IDLE_LVL, 1'b0, 1'b0, 1'b1};
    if (m_age <= W) return {m_data[W-m_age], 1'b1, 1'b0, 1'b0};
    if (PE == 1 && m_age == W + 1) return {^m_data, 1'b1, 1'b0, 1'b0};
    return {IDLE_LVL, 1'b0, 1'b1, 1'b0};
  endfunction

  // Advance one clock, update the model from the inputs seen at the edge,
  // and return at the falling edge where outputs are sampled.
  task automatic tick();
    @(posedge clk);
    if (clr) begin
      m_active = 1'b0;
    end else if (m_active) begin
      m_age++;
      if (m_age == L) m_active = 1'b0;
    end else if (load) begin
      m_active = 1'b1;
      m_age    = 1;
      m_data   = data_in;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    clr = 1'b1; load = 1'b1; load1 = 1'b1; data_in = W'($urandom);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({w, w_valid, done, ready} !== model_out())
        $display("FAIL reset_hold cyc=%0d got=%b exp=%b", cyc, {w, w_valid, done, ready},
                 model_out());
      else passes++;
    end
    clr = 1'b0; load = 1'b0; load1 = 1'b0;
    tick();
    checks++;
    if ({w, w_valid, done, ready} !== {IDLE_LVL, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset_release got=%b exp=%b", {w, w_valid, done, ready},
               {IDLE_LVL, 3'b001});
    else passes++;
  endtask

  task automatic test_basic();
    logic [W-1:0] got_bits;
    int ndone, nbits;
    got_bits = '0; ndone = 0; nbits = 0;
    load = 1'b1; data_in = 8'b0011_0101;
    tick();
    load = 1'b0; data_in = 8'hCC;
    for (int c = 1; c <= L + 1; c++) begin
      checks++;
      if ({w, w_valid, done, ready} !== model_out())
        $display("FAIL basic cyc=%0d got=%b exp=%b", c, {w, w_valid, done, ready}, model_out());
      else passes++;
      if (w_valid && c <= W) begin got_bits = {got_bits[W-2:0], w}; nbits++; end
      if (done) ndone++;
      if (c <= L) tick();
    end
    checks++;
    if (got_bits !== 8'b0011_0101 || nbits != W || ndone != 1)
      $display("FAIL basic_stream got=%b/%0d/%0d exp=00110101/%0d/1", got_bits, nbits, ndone, W);
    else passes++;
  endtask

  task automatic test_busy_ignore();
    int nvalid;
    nvalid = 0;
    load = 1'b1; data_in = 8'hA5;
    tick();
    load = 1'b0;
    for (int c = 1; c <= L + 4; c++) begin
      load    = (c == 3);
      data_in = (c == 3) ? 8'hFF : 8'h00;
      checks++;
      if ({w, w_valid, done, ready} !== model_out())
        $display("FAIL busy cyc=%0d got=%b exp=%b", c, {w, w_valid, done, ready}, model_out());
      else passes++;
      if (w_valid) nvalid++;
      tick();
    end
    load = 1'b0;
    checks++;
    if (nvalid != W + PE)
      $display("FAIL busy_count got=%0d exp=%0d", nvalid, W + PE);
    else passes++;
  endtask

  task automatic test_abort();
    int ndone;
    ndone = 0;
    load = 1'b1; data_in = 8'hF0;
    tick();
    load = 1'b0;
    for (int c = 1; c <= L + 3; c++) begin
      clr = (c == 4);
      checks++;
      if ({w, w_valid, done, ready} !== model_out())
        $display("FAIL abort cyc=%0d got=%b exp=%b", c, {w, w_valid, done, ready}, model_out());
      else passes++;
      if (done) ndone++;
      tick();
      if (c == 4) begin
        checks++;
        if ({w, w_valid, ready} !== {IDLE_LVL, 1'b0, 1'b1})
          $display("FAIL abort_idle got=%b exp=%b", {w, w_valid, ready}, {IDLE_LVL, 2'b01});
        else passes++;
      end
    end
    clr = 1'b0;
    checks++;
    if (ndone != 0) $display("FAIL abort_done got=%0d exp=0", ndone);
    else passes++;
  endtask

  task automatic test_back_to_back();
    load = 1'b1; data_in = 8'h81;
    tick();
    data_in = 8'h7E;
    for (int c = 1; c <= 2 * L + 1; c++) begin
      checks++;
      if ({w, w_valid, done, ready} !== model_out())
        $display("FAIL b2b cyc=%0d got=%b exp=%b", c, {w, w_valid, done, ready}, model_out());
      else passes++;
      if (c == L + 1) begin
        checks++;
        if ({w, w_valid} !== 2'b01)
          $display("FAIL b2b_second_first got=%b exp=01", {w, w_valid});
        else passes++;
      end
      if (c == 2 * L - 1) load = 1'b0;
      tick();
    end
    load = 1'b0;
    for (int i = 0; i < L; i++) tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      load    = ($urandom_range(0, 3) == 0);
      data_in = W'($urandom);
      clr     = ($urandom_range(0, 60) == 0);
      tick();
      checks++;
      if ({w, w_valid, done, ready} !== model_out())
        $display("FAIL random cyc=%0d got=%b exp=%b", cyc, {w, w_valid, done, ready},
                 model_out());
      else passes++;
    end
    load = 1'b0; clr = 1'b0;
    for (int i = 0; i < L; i++) tick();
  endtask

  task automatic test_width1();
    logic [3:0] exp_seq[4];
    logic [0:0] bitv;
    bitv = 1'($urandom);
    // {w, w_valid, done, ready} per cycle after acceptance
    exp_seq[0] = {bitv, 3'b100};
    if (PE == 1) begin
      exp_seq[1] = {bitv, 3'b100};
      exp_seq[2] = {IDLE_LVL, 3'b010};
      exp_seq[3] = {IDLE_LVL, 3'b001};
    end else begin
      exp_seq[1] = {IDLE_LVL, 3'b010};
      exp_seq[2] = {IDLE_LVL, 3'b001};
      exp_seq[3] = {IDLE_LVL, 3'b001};
    end
    load1 = 1'b1; data1 = bitv;
    tick();
    load1 = 1'b0; data1 = ~bitv;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if ({w1, w_valid1, done1, ready1} !== exp_seq[c])
        $display("FAIL width1 cyc=%0d got=%b exp=%b", c + 1, {w1, w_valid1, done1, ready1},
                 exp_seq[c]);
      else passes++;
      tick();
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_busy_ignore();
    test_abort();
    test_back_to_back();
    test_width1();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
